fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter RAM_LAT, default 2, meaning I_RAM read latency in cycles per cache refill (legal range 1..15).
REQ-002 SHALL provide port g_clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL provide port g_clr  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port run  input  1  fetch enable.
REQ-005 SHALL provide port stall  input  1  stage two cannot accept PSR0 this cycle.
REQ-006 SHALL provide port flush  input  1  taken branch; PC reload from target path.
REQ-007 SHALL provide port i_pending  input  1  interrupt pending from MHVPIS.
REQ-008 SHALL provide port i_odv  input  1  I_CACHE hit / output data valid.
REQ-009 SHALL provide port pc_ctl  output  2  program_counter mode: 00 hold, 01 increment, 10 load; 11 never driven.
REQ-010 SHALL provide port pc_mux_sel  output  1  PC_MUX select: 1 = interrupt vector, 0 = branch target.
REQ-011 SHALL provide ports imar_ld, ir_ld, psr0_ld  output  1 each  register load strobes.
REQ-012 SHALL provide ports cache_rd, cache_fill  output  1 each  I_CACHE lookup and refill-write strobes.
REQ-013 SHALL provide ports ram_ce, ram_rw  output  1 each  I_RAM chip enable and read select (1 = read).
REQ-014 SHALL provide port i_ack  output  1  one-cycle interrupt acknowledge.
REQ-015 SHALL provide port state  output  3  current FSM state, for debug.
REQ-016 SHALL provide ports hit_cnt, miss_cnt  output  8 each  performance counters.

Function
REQ-017 SHALL implement states IDLE(0), FETCH(1), LOOKUP(2), FILL(3), ISSUE(4), VECTOR(5); codes 6-7 SHALL return to IDLE.
REQ-018 SHALL drive all strobes combinationally from current state and inputs; state, fill counter and flush_pend SHALL be registered.
REQ-019 IDLE: all strobes 0; run=1 -> FETCH.
REQ-020 FETCH: imar_ld=1 -> LOOKUP.
REQ-021 LOOKUP: cache_rd=1; i_odv=1 -> ir_ld=1, pc_ctl=01, hit event, -> ISSUE; i_odv=0 -> miss event, load counter with RAM_LAT, -> FILL.
REQ-022 FILL: ram_ce=1, ram_rw=1 each cycle; counter decrements; in the cycle the counter equals 1, cache_fill=1 and next state is LOOKUP.
REQ-023 ISSUE: stall=1 -> psr0_ld=0, remain; stall=0 -> psr0_ld=1, then i_pending=1 -> VECTOR, else run=1 -> FETCH, else IDLE.
REQ-024 VECTOR: pc_mux_sel=1, pc_ctl=10, i_ack=1 for exactly one cycle -> FETCH.
REQ-025 flush=1 in FETCH, LOOKUP, ISSUE or VECTOR: pc_ctl=10, pc_mux_sel=0, ir_ld=psr0_ld=i_ack=0, -> FETCH; flush overrides every other transition.
REQ-026 flush=1 in FILL: set flush_pend; refill SHALL complete; on exit, flush_pend applies the REQ-025 reload in place of the LOOKUP transition, then clears.
REQ-027 flush in IDLE SHALL be ignored.
REQ-028 Interrupt SHALL be taken only at the ISSUE boundary; i_pending in other states SHALL not change the sequence.
REQ-029 run=0 SHALL not abort an in-flight instruction; the block returns to IDLE from ISSUE.
REQ-030 Hit path throughput SHALL be one instruction per 3 cycles with stall=0; a miss SHALL add RAM_LAT+1 cycles.

Reset
REQ-031 g_clr=1 at a rising edge SHALL force state=IDLE, counter=0, flush_pend=0, hit_cnt=miss_cnt=0, from any state including FILL.
REQ-032 While g_clr=1 all strobes SHALL be 0 and pc_ctl=00.

Configuration
REQ-033 With macro FETCH_CTRL_PERF_EN defined, hit_cnt/miss_cnt SHALL count hit/miss events, saturating at 255.
REQ-034 Without FETCH_CTRL_PERF_EN, hit_cnt and miss_cnt SHALL be constant 0 and no counter registers SHALL be built.

Verification
REQ-035 Reset, run=1, i_odv=1 always -> states 1,2,4 repeating; psr0_ld pulses every 3rd cycle; pc_ctl=01 once per instruction.
REQ-036 RAM_LAT=2, i_odv=0 on first LOOKUP then 1 -> FILL lasts 2 cycles, ram_ce=1 both, cache_fill=1 in second, then LOOKUP hit; miss_cnt=1, hit_cnt=1.
REQ-037 flush=1 during FILL cycle 1 -> fill completes, next cycle pc_ctl=10, pc_mux_sel=0, state FETCH; no ir_ld.
REQ-038 i_pending=1 with stall=1 for 2 cycles in ISSUE -> ISSUE held, psr0_ld=0; then stall=0 -> psr0_ld=1, next cycle VECTOR with i_ack=1, pc_mux_sel=1.
REQ-039 g_clr=1 mid-FILL -> next cycle state=0, all strobes 0, counters 0.
REQ-040 PERF build, 300 consecutive hits -> hit_cnt saturates at 255; non-PERF build -> hit_cnt stays 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: walks FETCH/LOOKUP/ISSUE, runs an I_RAM refill on a cache miss, and takes interrupts at ISSUE.
// Building with FETCH_CTRL_PERF_EN defined adds saturating hit/miss counters.
module fetch_ctrl #(
  parameter int unsigned RAM_LAT = 2
) (
  input  logic       g_clk,
  input  logic       g_clr,
  input  logic       run,
  input  logic       stall,
  input  logic       flush,
  input  logic       i_pending,
  input  logic       i_odv,
  output logic [1:0] pc_ctl,
  output logic       pc_mux_sel,
  output logic       imar_ld,
  output logic       ir_ld,
  output logic       psr0_ld,
  output logic       cache_rd,
  output logic       cache_fill,
  output logic       ram_ce,
  output logic       ram_rw,
  output logic       i_ack,
  output logic [2:0] state,
  output logic [7:0] hit_cnt,
  output logic [7:0] miss_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOOKUP = 3'd2,
    FILL   = 3'd3,
    ISSUE  = 3'd4,
    VECTOR = 3'd5
  } state_e;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [3:0] LAT     = 4'(RAM_LAT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       flush_pend_q, flush_pend_d;
  logic       hit_ev, miss_ev;

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    pc_ctl       = PC_HOLD;
    pc_mux_sel   = 1'b0;
    imar_ld      = 1'b0;
    ir_ld        = 1'b0;
    psr0_ld      = 1'b0;
    cache_rd     = 1'b0;
    cache_fill   = 1'b0;
    ram_ce       = 1'b0;
    ram_rw       = 1'b0;
    i_ack        = 1'b0;
    hit_ev       = 1'b0;
    miss_ev      = 1'b0;
    if (!g_clr) begin
      case (state_q)
        IDLE: begin
          if (run) state_d = FETCH;
        end
        FETCH: begin
          imar_ld = 1'b1;
          if (flush) begin
            pc_ctl  = PC_LOAD;
            state_d = FETCH;
          end else begin
            state_d = LOOKUP;
          end
        end
        LOOKUP: begin
          cache_rd = 1'b1;
          if (flush) begin
            pc_ctl  = PC_LOAD;
            state_d = FETCH;
          end else if (i_odv) begin
            ir_ld   = 1'b1;
            pc_ctl  = PC_INC;
            hit_ev  = 1'b1;
            state_d = ISSUE;
          end else begin
            miss_ev = 1'b1;
            cnt_d   = LAT;
            state_d = FILL;
          end
        end
        FILL: begin
          // A flush cannot abort the refill; it is remembered and applied on exit.
          ram_ce = 1'b1;
          ram_rw = 1'b1;
          if (flush) flush_pend_d = 1'b1;
          if (cnt_q <= 4'd1) begin
            cache_fill = 1'b1;
            cnt_d      = 4'd0;
            if (flush_pend_q || flush) begin
              pc_ctl       = PC_LOAD;
              flush_pend_d = 1'b0;
              state_d      = FETCH;
            end else begin
              state_d = LOOKUP;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ISSUE: begin
          if (flush) begin
            pc_ctl  = PC_LOAD;
            state_d = FETCH;
          end else if (!stall) begin
            psr0_ld = 1'b1;
            if (i_pending)  state_d = VECTOR;
            else if (run)   state_d = FETCH;
            else            state_d = IDLE;
          end
        end
        VECTOR: begin
          pc_ctl = PC_LOAD;
          if (!flush) begin
            pc_mux_sel = 1'b1;
            i_ack      = 1'b1;
          end
          state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign state = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [7:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      hit_cnt_q  <= 8'd0;
      miss_cnt_q <= 8'd0;
    end else begin
      if (hit_ev && hit_cnt_q != 8'hFF)   hit_cnt_q  <= hit_cnt_q + 8'd1;
      if (miss_ev && miss_cnt_q != 8'hFF) miss_cnt_q <= miss_cnt_q + 8'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_ev;
  assign unused_ev = hit_ev ^ miss_ev;
  assign hit_cnt   = 8'd0;
  assign miss_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int LAT = 2;

  logic       g_clk = 1'b0;
  logic       g_clr, run, stall, flush, i_pending, i_odv;
  logic [1:0] pc_ctl;
  logic       pc_mux_sel, imar_ld, ir_ld, psr0_ld, cache_rd, cache_fill;
  logic       ram_ce, ram_rw, i_ack;
  logic [2:0] state;
  logic [7:0] hit_cnt, miss_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  fetch_ctrl #(.RAM_LAT(LAT)) dut (
    .g_clk(g_clk), .g_clr(g_clr), .run(run), .stall(stall), .flush(flush),
    .i_pending(i_pending), .i_odv(i_odv), .pc_ctl(pc_ctl), .pc_mux_sel(pc_mux_sel),
    .imar_ld(imar_ld), .ir_ld(ir_ld), .psr0_ld(psr0_ld), .cache_rd(cache_rd),
    .cache_fill(cache_fill), .ram_ce(ram_ce), .ram_rw(ram_rw), .i_ack(i_ack),
    .state(state), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 g_clk = ~g_clk;

  logic [29:0] act_v;
  assign act_v = {pc_ctl, pc_mux_sel, imar_ld, ir_ld, psr0_ld, cache_rd, cache_fill,
                  ram_ce, ram_rw, i_ack, state, hit_cnt, miss_cnt};

  // Behavioural model: where the fetch is, how many refill cycles remain, outstanding flush, event totals.
  int m_where = 0;
  int m_left = 0;
  bit m_pend = 1'b0;
  int m_hits = 0;
  int m_miss = 0;

  always begin
    logic [1:0] e_pc;
    logic e_mux, e_imar, e_ir, e_psr, e_crd, e_cfill, e_ram, e_ack;
    logic [29:0] exp_v;
    int n_where, n_left, n_hits, n_miss;
    bit n_pend, redirect;
    @(negedge g_clk);
    e_pc = 2'b00; e_mux = 0; e_imar = 0; e_ir = 0; e_psr = 0;
    e_crd = 0; e_cfill = 0; e_ram = 0; e_ack = 0;
    n_where = m_where; n_left = m_left; n_pend = m_pend;
    n_hits = m_hits; n_miss = m_miss;
    redirect = 1'b0;
    if (g_clr) begin
      n_where = 0; n_left = 0; n_pend = 0; n_hits = 0; n_miss = 0;
    end else if (m_where == 0) begin
      if (run) n_where = 1;
    end else if (m_where == 3) begin
      e_ram = 1;
      n_left = m_left - 1;
      if (flush) n_pend = 1;
      if (n_left == 0) begin
        e_cfill = 1;
        redirect = m_pend | flush;
        n_pend = 0;
        n_where = redirect ? 1 : 2;
      end
    end else if (flush) begin
      // a branch wins over whatever else this step would have done
      redirect = 1'b1;
      e_imar = (m_where == 1);
      e_crd = (m_where == 2);
      n_where = 1;
    end else if (m_where == 1) begin
      e_imar = 1; n_where = 2;
    end else if (m_where == 2) begin
      e_crd = 1;
      if (i_odv) begin
        e_ir = 1; e_pc = 2'b01; n_hits = m_hits + 1; n_where = 4;
      end else begin
        n_miss = m_miss + 1; n_left = LAT; n_where = 3;
      end
    end else if (m_where == 4) begin
      if (!stall) begin
        e_psr = 1;
        n_where = i_pending ? 5 : (run ? 1 : 0);
      end
    end else begin
      e_mux = 1; e_pc = 2'b10; e_ack = 1; n_where = 1;
    end
    if (redirect) e_pc = 2'b10;
    exp_v = {e_pc, e_mux, e_imar, e_ir, e_psr, e_crd, e_cfill, e_ram, e_ram, e_ack,
             3'(m_where),
             PERF ? 8'((m_hits > 255) ? 255 : m_hits) : 8'd0,
             PERF ? 8'((m_miss > 255) ? 255 : m_miss) : 8'd0};
    if (chk_en) begin
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
    end
    @(posedge g_clk);
    m_where = n_where; m_left = n_left; m_pend = n_pend;
    m_hits = n_hits; m_miss = n_miss;
  end

  logic [1:0] s_pc;
  logic s_mux, s_imar, s_ir, s_psr, s_crd, s_cfill, s_ce, s_ack;
  logic [2:0] s_st;
  logic [7:0] s_hit, s_miss;

  task automatic cyc(input logic c, input logic r, input logic st, input logic fl,
                     input logic ip, input logic od);
    g_clr = c; run = r; stall = st; flush = fl; i_pending = ip; i_odv = od;
    @(negedge g_clk);
    #1;
    s_pc = pc_ctl; s_mux = pc_mux_sel; s_imar = imar_ld; s_ir = ir_ld; s_psr = psr0_ld;
    s_crd = cache_rd; s_cfill = cache_fill; s_ce = ram_ce; s_ack = i_ack;
    s_st = state; s_hit = hit_cnt; s_miss = miss_cnt;
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    int np, ninc, es;
    g_clr = 1; run = 1; stall = 0; flush = 0; i_pending = 0; i_odv = 1;
    @(posedge g_clk);
    #1;
    chk_en = 1'b1;

    // reset holds everything quiet even with run asserted
    cyc(1, 1, 0, 0, 0, 1);
    chk("rst_state", s_st, 0);
    chk("rst_pc_ctl", s_pc, 0);
    chk("rst_imar", s_imar, 0);
    chk("rst_hit", s_hit, 0);

    // back-to-back hits: 1,2,4 repeating
    cyc(0, 1, 0, 0, 0, 1);
    chk("idle_state", s_st, 0);
    np = 0; ninc = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 0, 0, 1);
      np += int'(s_psr);
      ninc += int'(s_pc == 2'b01);
      es = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 4);
      chk("hit_seq_state", s_st, es);
    end
    chk("hit_psr0_pulses", np, 3);
    chk("hit_pc_inc", ninc, 3);

    // miss with two-cycle refill, then hit
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("miss_lookup_ir", s_ir, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("fill1_state", s_st, 3);
    chk("fill1_ram_ce", s_ce, 1);
    chk("fill1_cache_fill", s_cfill, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("fill2_ram_ce", s_ce, 1);
    chk("fill2_cache_fill", s_cfill, 1);
    cyc(0, 1, 0, 0, 0, 1);
    chk("refetch_state", s_st, 2);
    chk("refetch_ir", s_ir, 1);
    cyc(0, 1, 0, 0, 0, 1);
    chk("miss_cnt", s_miss, PERF ? 1 : 0);
    chk("hit_cnt4", s_hit, PERF ? 4 : 0);

    // flush during first refill cycle is deferred to refill exit
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    chk("fflush_state", s_st, 3);
    cyc(0, 1, 0, 0, 0, 1);
    chk("fflush_cache_fill", s_cfill, 1);
    chk("fflush_pc_ctl", s_pc, 2);
    chk("fflush_mux", s_mux, 0);
    chk("fflush_ir", s_ir, 0);
    cyc(0, 1, 0, 0, 0, 1);
    chk("fflush_next_state", s_st, 1);

    // interrupt held off by stall, then taken
    cyc(0, 1, 0, 0, 1, 1);
    cyc(0, 1, 1, 0, 1, 1);
    chk("stall1_state", s_st, 4);
    chk("stall1_psr0", s_psr, 0);
    cyc(0, 1, 1, 0, 1, 1);
    chk("stall2_psr0", s_psr, 0);
    cyc(0, 1, 0, 0, 1, 1);
    chk("issue_psr0", s_psr, 1);
    cyc(0, 1, 0, 0, 0, 1);
    chk("vec_state", s_st, 5);
    chk("vec_ack", s_ack, 1);
    chk("vec_mux", s_mux, 1);
    chk("vec_pc_ctl", s_pc, 2);

    // branch in ISSUE
    cyc(0, 1, 0, 0, 0, 1);
    chk("post_vec_state", s_st, 1);
    cyc(0, 1, 0, 0, 1, 1);
    cyc(0, 1, 0, 1, 0, 1);
    chk("iflush_pc_ctl", s_pc, 2);
    chk("iflush_psr0", s_psr, 0);
    // run dropped: instruction completes, then IDLE; flush in IDLE ignored
    cyc(0, 0, 0, 0, 0, 1);
    chk("iflush_next_state", s_st, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("runoff_psr0", s_psr, 1);
    cyc(0, 0, 0, 1, 0, 1);
    chk("idle_flush_state", s_st, 0);
    chk("idle_flush_pc", s_pc, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("idle_stays", s_st, 0);

    // reset in the middle of a refill
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("fillrst_ram_ce", s_ce, 0);
    chk("fillrst_cache_fill", s_cfill, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("fillrst_state", s_st, 0);
    chk("fillrst_hit", s_hit, 0);
    chk("fillrst_miss", s_miss, 0);

    // 300 consecutive hits
    cyc(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 900; i++) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("hit_saturate", s_hit, PERF ? 255 : 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
